// File: rtl/jdrosent_edge_pulse_gen.sv
// jdrosent_edge_pulse_gen
// Generates a programmable burst of rising edges for a downstream edge
// detector. A rising edge on trig (while idle, with count != 0) starts a
// burst of `count` pulses. Each pulse is high for high_len+1 cycles, and
// consecutive pulses are separated by low_len+1 low cycles. The burst
// configuration is captured at start, so the config inputs may change
// freely while a burst runs.
module jdrosent_edge_pulse_gen #(
  parameter int CNT_W   = 3,
  parameter int LEN_W   = 2,
  parameter int LOW_DEF = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remaining_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             trig_q;
  logic [CNT_W-1:0] rem;
  logic [LEN_W-1:0] hcnt;
  logic [LEN_W-1:0] lcnt;
  logic [LEN_W-1:0] hcnt_len;
  logic [LEN_W-1:0] lcnt_len;
  logic             start;
  logic             more_pulses;
  logic             pulse_d;
  logic             busy_d;
  logic             done_d;

  // A new burst only begins from idle on a genuine 0->1 edge of trig.
  assign start       = trig & ~trig_q & (state_q == IDLE) & (count != '0);
  assign more_pulses = (rem > CNT_W'(1));
  assign remaining_o = rem;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // its inputs as they were before the edge, independent of block order.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance when the active phase counter reaches zero.
  always_comb begin
    // NOTE: default assignment first, so every path drives state_d and no
    // latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = HIGH;
      HIGH:    if (hcnt == '0) state_d = more_pulses ? LOW : IDLE;
      LOW:     if (lcnt == '0) state_d = HIGH;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: outputs follow the state being entered, then get
  // registered so pulse_o changes exactly on the transition edge.
  always_comb begin
    pulse_d = (state_d == HIGH);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == HIGH) && (state_d == IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      pulse_o <= pulse_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Burst datapath: trig history, latched config and phase/pulse counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // trig_q resets high so a trig held through reset release is not an edge.
      trig_q   <= 1'b1;
      rem      <= '0;
      hcnt     <= '0;
      lcnt     <= '0;
      hcnt_len <= '0;
      lcnt_len <= LEN_W'(LOW_DEF);
    end else begin
      trig_q <= trig;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rem      <= count;
            hcnt     <= high_len;
            hcnt_len <= high_len;
            lcnt_len <= low_len;
          end
        end
        HIGH: begin
          if (hcnt == '0) begin
            if (more_pulses) begin
              rem  <= rem - CNT_W'(1);
              lcnt <= lcnt_len;
            end else begin
              rem <= '0;
            end
          end else begin
            hcnt <= hcnt - LEN_W'(1);
          end
        end
        LOW: begin
          if (lcnt == '0) begin
            hcnt <= hcnt_len;
          end else begin
            lcnt <= lcnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jdrosent_edge_pulse_gen.sv
// Testbench for jdrosent_edge_pulse_gen. A burst-level reference model
// expands each accepted start into a queue of expected per-cycle outputs;
// a compare process checks the DUT against it on every falling edge.
// Directed scenarios add literal expectations on top.
module tb_jdrosent_edge_pulse_gen;

  localparam int CNT_W = 3;
  localparam int LEN_W = 2;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             trig     = 1'b1;
  logic [CNT_W-1:0] count    = 3'd3;
  logic [LEN_W-1:0] high_len = 2'd1;
  logic [LEN_W-1:0] low_len  = 2'd0;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] remaining_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jdrosent_edge_pulse_gen #(
    .CNT_W  (CNT_W),
    .LEN_W  (LEN_W),
    .LOW_DEF(0)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .trig       (trig),
    .count      (count),
    .high_len   (high_len),
    .low_len    (low_len),
    .pulse_o    (pulse_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .remaining_o(remaining_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic             p;
    logic             b;
    logic             d;
    logic [CNT_W-1:0] r;
  } exp_t;

  exp_t q[$];
  exp_t cur     = '0;
  logic m_trig_q = 1'b1;

  // Expand one burst into the output values seen after each clock edge.
  task automatic build(input int n, input int h, input int l);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k <= h; k++) q.push_back('{1'b1, 1'b1, 1'b0, CNT_W'(n - i)});
      if (i != n - 1)
        for (int k = 0; k <= l; k++) q.push_back('{1'b0, 1'b1, 1'b0, CNT_W'(n - i - 1)});
    end
    q.push_back('{1'b0, 1'b0, 1'b1, CNT_W'(0)});
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur      = '0;
        m_trig_q = 1'b1;
      end else begin
        // Idle means nothing is left to play out at this sampling edge.
        if (q.size() == 0 && trig && !m_trig_q && count != '0)
          build(int'(count), int'(high_len), int'(low_len));
        m_trig_q = trig;
        if (q.size() > 0) cur = q.pop_front();
        else cur = '0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_pulse", pulse_o, cur.p);
      check("cyc_busy", busy_o, cur.b);
      check("cyc_done", done_o, cur.d);
      check("cyc_remaining", remaining_o, cur.r);
    end
  end

  // Downstream rising-edge detector on the same clock.
  logic det_prev  = 1'b0;
  int   det_edges = 0;
  always @(posedge clk) begin
    det_prev <= pulse_o;
    if (pulse_o && !det_prev) det_edges <= det_edges + 1;
  end

  // Watch a burst that starts at the next edge; drops trig after one cycle.
  task automatic observe(input int limit, input int period, output int edges,
                         output int busy_n, output int period_bad, output logic got_done);
    logic prev;
    int   last;
    prev = 1'b0; last = -1;
    edges = 0; busy_n = 0; period_bad = 0; got_done = 1'b0;
    for (int c = 0; c < limit && !got_done; c++) begin
      @(negedge clk);
      trig = 1'b0;
      if (busy_o) busy_n++;
      if (pulse_o && !prev) begin
        edges++;
        if (last >= 0 && period != 0 && (c - last) != period) period_bad++;
        last = c;
      end
      prev = pulse_o;
      if (done_o) got_done = 1'b1;
    end
  endtask

  logic [8:0] pv, bv, dv;
  int         rem_exp [9] = '{3, 3, 2, 2, 2, 1, 1, 1, 0};
  int         edges, busy_n, pbad, e0;
  logic       got_done;

  initial begin
    // Reset release with trig held high: no burst.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("hold_pulse", pulse_o, 1'b0);
      check("hold_busy", busy_o, 1'b0);
    end

    // count=3, high_len=1, low_len=0 with ignored mid-burst activity.
    trig = 1'b0;
    @(negedge clk);
    trig = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 9) begin
        pv[i] = pulse_o; bv[i] = busy_o; dv[i] = done_o;
        check("burst3_remaining", remaining_o, rem_exp[i]);
      end else begin
        check("edge_at_done_ignored", busy_o, 1'b0);
      end
      case (i)
        1: count = 3'd7;
        2, 4, 6: trig = 1'b0;
        3, 5, 7: trig = 1'b1;
        9: trig = 1'b0;
        default: ;
      endcase
    end
    check("burst3_pulse_seq", pv, 9'b011011011);
    check("burst3_busy_seq", bv, 9'b011111111);
    check("burst3_done_seq", dv, 9'b100000000);

    // Burst of 7 (config changed mid-burst above), then one a cycle after done.
    @(negedge clk);
    trig = 1'b1;
    observe(200, 0, edges, busy_n, pbad, got_done);
    check("burst7a_done", got_done, 1'b1);
    check("burst7a_edges", edges, 7);
    trig = 1'b1;
    observe(200, 0, edges, busy_n, pbad, got_done);
    check("burst7b_done", got_done, 1'b1);
    check("burst7b_edges", edges, 7);

    // Reset in the second high phase of a count=7/3/3 burst.
    count = 3'd7; high_len = 2'd3; low_len = 2'd3; trig = 1'b1;
    repeat (10) begin
      @(negedge clk);
      trig = 1'b0;
    end
    check("pre_reset_pulse", pulse_o, 1'b1);
    check("pre_reset_remaining", remaining_o, 6);
    #2 rst = 1'b1;
    #1;
    check("async_pulse", pulse_o, 1'b0);
    check("async_busy", busy_o, 1'b0);
    check("async_done", done_o, 1'b0);
    check("async_remaining", remaining_o, 0);
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", done_o, 1'b0);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_reset_done", done_o, 1'b0);
    trig = 1'b1;
    observe(200, 8, edges, busy_n, pbad, got_done);
    check("burst7p8_done", got_done, 1'b1);
    check("burst7p8_edges", edges, 7);
    check("burst7p8_busy", busy_n, 52);
    check("burst7p8_period", pbad, 0);

    // Closed loop into the edge detector.
    count = 3'd5; high_len = 2'd0; low_len = 2'd1;
    @(negedge clk);
    e0 = det_edges;
    trig = 1'b1;
    observe(200, 3, edges, busy_n, pbad, got_done);
    check("loop_done", got_done, 1'b1);
    check("loop_det_edges", det_edges - e0, 5);
    check("loop_period", pbad, 0);

    // count=0 never starts a burst.
    count = 3'd0;
    @(negedge clk);
    trig = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("count0_busy", busy_o, 1'b0);
      check("count0_done", done_o, 1'b0);
      check("count0_pulse", pulse_o, 1'b0);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) trig = ~trig;
      if ($urandom_range(0, 5) == 0) count = CNT_W'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) high_len = LEN_W'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) low_len = LEN_W'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
